aead_block_sequencer: RTL and testbench
=======================================

Name: aead_block_sequencer

Overview:
Host-side initiator for chacha20_poly1305_core. It accepts a 128-bit streaming message and packs it into 512-bit blocks. It drives the core's init/next/done strobes and key/nonce/encdec, and unpacks core_data_out back into a 128-bit output stream. At the end it collects the 128-bit tag, checks it against an expected tag on decrypt, and flags timeouts, so the core never needs hand-sequenced strobes.

Parameters:
TIMEOUT_CYCLES, 5000, maximum cycles waited for core_ready, core_valid or core_tag_ok before aborting
CNT_W, 13, width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a message; accepted only in IDLE
encdec_in  in  1  1=encrypt, 0=decrypt; latched on start
key_in  in  256  key; latched on start
nonce_in  in  96  nonce; latched on start
expected_tag  in  128  reference tag for decrypt; sampled in WAIT_TAG
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&&s_ready
s_data  in  128  input word
s_last  in  1  marks the final word of the message
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts the output word
m_data  out  128  output word
m_last  out  1  final output word of the message
tag_out  out  128  captured core tag; holds until next start
tag_valid  out  1  one-cycle pulse when tag_out updates
auth_fail  out  1  tag mismatch on decrypt; sticky until next accepted start
err  out  1  timeout abort; sticky until next accepted start
busy  out  1  high in every state except IDLE
core_init, core_next, core_done  out  1 each  single-cycle strobes to the core
core_encdec  out  1  latched encdec
core_key  out  256  latched key
core_nonce  out  96  latched nonce
core_data_in  out  512  packed block
core_ready, core_valid, core_tag_ok  in  1 each  core status
core_data_out  in  512  core result block
core_tag  in  128  core tag

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. Every output is 0, including all core strobes, latched registers, tag_out, auth_fail and err.
- States: IDLE, INIT, WAIT_RDY, FILL, NEXT, WAIT_VALID, DRAIN, FINAL, WAIT_TAG, ABORT.
- IDLE:
  - On start, latch key/nonce/encdec, clear err/auth_fail/tag_out and go to INIT.
  - start in any other state is ignored.
- INIT: core_init=1 for exactly one cycle, then WAIT_RDY.
- WAIT_RDY: wait for core_ready=1, then FILL.
- FILL:
  - s_ready=1. Word i (0..3) is written to core_data_in[511-128*i -: 128], so word 0 occupies the MSBs.
  - Exit to NEXT after the 4th word or after the word carrying s_last. Unfilled words are zeroed.
  - Record n = number of valid words (1..4) and last_blk = s_last.
- NEXT: core_next=1 for one cycle, then WAIT_VALID. core_data_in holds stable from FILL exit until core_valid is seen.
- WAIT_VALID:
  - Capture core_data_out on the first cycle core_valid=1, then DRAIN.
  - Later valid pulses are ignored.
- DRAIN:
  - Emit captured words 0..n-1 in order. m_data and m_valid hold stable until m_ready.
  - m_last=1 only on word n-1 when last_blk=1.
  - After the last handshake: go to FINAL if last_blk, else FILL.
  - s_ready=0 throughout DRAIN; there is no overlap of fill and drain.
- FINAL: core_done=1 for one cycle, then WAIT_TAG.
- WAIT_TAG: on core_tag_ok=1:
  - tag_out<=core_tag and pulse tag_valid.
  - auth_fail<=(!core_encdec && core_tag!=expected_tag); auth_fail is never set on encrypt.
  - Go to IDLE.
- Timeout:
  - The counter clears on entry to WAIT_RDY, WAIT_VALID and WAIT_TAG, and increments each cycle while waiting.
  - When the count reaches TIMEOUT_CYCLES without the awaited status: go to ABORT, set err=1, drop s_ready/m_valid, emit no strobes.
  - ABORT returns to IDLE the next cycle. Partial output is discarded and tag_valid is never pulsed.
- Status arriving on the same cycle the count reaches TIMEOUT_CYCLES counts as success; status takes priority.
- Minimum message length is one word; a message of exactly 4k words produces full blocks only.
- Mid-operation reset aborts with no further strobes. After release, the block requires a fresh start, which re-inits the core.

Test Plan:
- Encrypt, 4 words of cafebabedeadbeefcafebabedeadbeef:
  - core_init once, then core_next once, then core_done once.
  - core_data_in = {4{word}}; 4 output words, m_last on the 4th; tag_valid one pulse; auth_fail=0.
- 6-word message: two core_next pulses.
  - Second core_data_in = {w4,w5,256'h0}.
  - Outputs are exactly 6 words, m_last on the 6th.
- Decrypt with expected_tag equal to core_tag gives auth_fail=0. With expected_tag differing by bit 0, auth_fail=1 and it stays high until the next start.
- m_ready held low 10 cycles mid-drain: m_data stable, no word lost or duplicated; s_ready stays 0.
- core_valid never asserted: err=1 exactly TIMEOUT_CYCLES cycles after entering WAIT_VALID, return to IDLE, no tag_valid. A following start clears err.
- rst pulsed during DRAIN: all outputs 0 asynchronously. busy=0 after release; a new start completes normally.

Source files
------------

// File: rtl/aead_block_sequencer.sv
// Host-side sequencer for chacha20_poly1305_core: packs a 128-bit stream into
// 512-bit blocks, strobes the core, unpacks results and checks the final tag.
module aead_block_sequencer #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int CNT_W          = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         encdec_in,
  input  logic [255:0] key_in,
  input  logic [95:0]  nonce_in,
  input  logic [127:0] expected_tag,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_data,
  output logic         m_last,
  output logic [127:0] tag_out,
  output logic         tag_valid,
  output logic         auth_fail,
  output logic         err,
  output logic         busy,
  output logic         core_init,
  output logic         core_next,
  output logic         core_done,
  output logic         core_encdec,
  output logic [255:0] core_key,
  output logic [95:0]  core_nonce,
  output logic [511:0] core_data_in,
  input  logic         core_ready,
  input  logic         core_valid,
  input  logic         core_tag_ok,
  input  logic [511:0] core_data_out,
  input  logic [127:0] core_tag
);

  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_RDY, FILL, NEXT, WAIT_VALID, DRAIN, FINAL, WAIT_TAG, ABORT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       widx_reg;
  logic [1:0]       ridx_reg;
  logic [2:0]       nwords_reg;
  logic             last_blk_reg;
  logic [511:0]     out_buf_reg;
  logic [127:0]     out_words [4];
  logic             drain_last;
  logic             timeout_hit;

  // Word 0 of a block lives in the most significant 128 bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign out_words[gi] = out_buf_reg[511-128*gi -: 128];
  end

  assign s_ready     = (state_reg == FILL);
  assign m_valid     = (state_reg == DRAIN);
  assign busy        = (state_reg != IDLE);
  assign drain_last  = ({1'b0, ridx_reg} == (nwords_reg - 3'd1));
  assign m_last      = m_valid && last_blk_reg && drain_last;
  assign m_data      = m_valid ? out_words[ridx_reg] : '0;
  // The awaited status wins if it shows up on the final counted cycle.
  assign timeout_hit = (cnt_reg == CNT_LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      widx_reg     <= '0;
      ridx_reg     <= '0;
      nwords_reg   <= '0;
      last_blk_reg <= 1'b0;
      out_buf_reg  <= '0;
      tag_out      <= '0;
      tag_valid    <= 1'b0;
      auth_fail    <= 1'b0;
      err          <= 1'b0;
      core_init    <= 1'b0;
      core_next    <= 1'b0;
      core_done    <= 1'b0;
      core_encdec  <= 1'b0;
      core_key     <= '0;
      core_nonce   <= '0;
      core_data_in <= '0;
    end else begin
      tag_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            core_encdec <= encdec_in;
            core_key    <= key_in;
            core_nonce  <= nonce_in;
            err         <= 1'b0;
            auth_fail   <= 1'b0;
            tag_out     <= '0;
            core_init   <= 1'b1;
            state_reg   <= INIT;
          end
        end
        INIT: begin
          core_init <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (core_ready) begin
            widx_reg     <= '0;
            core_data_in <= '0;
            state_reg    <= FILL;
          end else if (timeout_hit) begin
            err       <= 1'b1;
            state_reg <= ABORT;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        FILL: begin
          if (s_valid) begin
            for (int i = 0; i < 4; i++) begin
              if (widx_reg == 2'(i)) core_data_in[511-128*i -: 128] <= s_data;
            end
            widx_reg <= widx_reg + 2'd1;
            if (widx_reg == 2'd3 || s_last) begin
              nwords_reg   <= {1'b0, widx_reg} + 3'd1;
              last_blk_reg <= s_last;
              core_next    <= 1'b1;
              state_reg    <= NEXT;
            end
          end
        end
        NEXT: begin
          core_next <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= WAIT_VALID;
        end
        WAIT_VALID: begin
          if (core_valid) begin
            out_buf_reg <= core_data_out;
            ridx_reg    <= '0;
            state_reg   <= DRAIN;
          end else if (timeout_hit) begin
            err       <= 1'b1;
            state_reg <= ABORT;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (drain_last) begin
              if (last_blk_reg) begin
                core_done <= 1'b1;
                state_reg <= FINAL;
              end else begin
                widx_reg     <= '0;
                core_data_in <= '0;
                state_reg    <= FILL;
              end
            end else begin
              ridx_reg <= ridx_reg + 2'd1;
            end
          end
        end
        FINAL: begin
          core_done <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= WAIT_TAG;
        end
        WAIT_TAG: begin
          if (core_tag_ok) begin
            tag_out   <= core_tag;
            tag_valid <= 1'b1;
            auth_fail <= !core_encdec && (core_tag != expected_tag);
            state_reg <= IDLE;
          end else if (timeout_hit) begin
            err       <= 1'b1;
            state_reg <= ABORT;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ABORT: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aead_block_sequencer.sv
// Bench for aead_block_sequencer: a behavioural core stub plus a message-level
// model predicting blocks, output words and tags for random messages.
module tb_aead_block_sequencer;

  localparam int TMO    = 40;
  localparam int BUDGET = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, encdec_in;
  logic [255:0] key_in;
  logic [95:0]  nonce_in;
  logic [127:0] expected_tag;
  logic         s_valid, s_ready, s_last;
  logic [127:0] s_data;
  logic         m_valid, m_ready, m_last;
  logic [127:0] m_data;
  logic [127:0] tag_out;
  logic         tag_valid, auth_fail, err, busy;
  logic         core_init, core_next, core_done, core_encdec;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [511:0] core_data_in;
  logic         core_ready, core_valid, core_tag_ok;
  logic [511:0] core_data_out;
  logic [127:0] core_tag;

  always #5 clk = ~clk;

  aead_block_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .encdec_in(encdec_in), .key_in(key_in),
    .nonce_in(nonce_in), .expected_tag(expected_tag), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .tag_out(tag_out),
    .tag_valid(tag_valid), .auth_fail(auth_fail), .err(err), .busy(busy),
    .core_init(core_init), .core_next(core_next), .core_done(core_done),
    .core_encdec(core_encdec), .core_key(core_key), .core_nonce(core_nonce),
    .core_data_in(core_data_in), .core_ready(core_ready), .core_valid(core_valid),
    .core_tag_ok(core_tag_ok), .core_data_out(core_data_out), .core_tag(core_tag)
  );

  int n_cmp = 0;
  int n_fail = 0;

  logic [127:0] msg [$];
  logic [255:0] cur_key;
  logic [95:0]  cur_nonce;
  logic         cur_encdec;
  logic [127:0] exp_tag;
  logic         exp_auth;
  int init_cnt, next_cnt, done_cnt, tag_pulses;

  bit valid_en = 1'b1;
  bit dup_en = 1'b0;
  bit v_pend, t_pend, dup_pend;
  int rdy_wait, v_wait, t_wait;
  logic [31:0]  blk_no;
  logic [511:0] v_data;
  logic [127:0] fold;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: block b holds message words 4b..4b+3, word 0 in the MSBs, zero padded.
  function automatic logic [511:0] exp_block(input int b);
    logic [511:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      if (4*b + i < msg.size()) r[511-128*i -: 128] = msg[4*b + i];
    end
    return r;
  endfunction

  // Stub transform: word j is xored with a key half and its block number.
  function automatic logic [127:0] exp_word(input int j);
    logic [31:0]  q = 32'(j / 4);
    logic [127:0] k = (j % 2 == 0) ? cur_key[255:128] : cur_key[127:0];
    return msg[j] ^ k ^ {4{q}};
  endfunction

  function automatic logic [127:0] model_tag();
    logic [127:0] t = {cur_nonce, 32'h0};
    foreach (msg[j]) t ^= msg[j];
    return t;
  endfunction

  // Behavioural core: ready after init, one valid pulse per next, tag after done.
  always @(negedge clk) begin
    if (rst) begin
      core_ready = 1'b0; core_valid = 1'b0; core_tag_ok = 1'b0;
      v_pend = 1'b0; t_pend = 1'b0; dup_pend = 1'b0;
    end else begin
      core_valid = 1'b0;
      core_tag_ok = 1'b0;
      if (core_init) begin
        core_ready = 1'b0; rdy_wait = $urandom_range(0, 4); blk_no = '0; fold = '0;
      end else if (!core_ready) begin
        if (rdy_wait == 0) core_ready = 1'b1; else rdy_wait--;
      end
      if (dup_pend) begin
        core_valid = 1'b1; core_data_out = {4{rand128()}}; dup_pend = 1'b0;
      end
      if (core_next) begin
        v_data = core_data_in ^ {core_key, core_key} ^ {16{blk_no}};
        fold ^= core_data_in[511:384] ^ core_data_in[383:256] ^ core_data_in[255:128] ^ core_data_in[127:0];
        blk_no++;
        v_pend = 1'b1; v_wait = $urandom_range(0, 5);
      end else if (v_pend) begin
        if (v_wait == 0) begin
          core_valid = valid_en; core_data_out = v_data; v_pend = 1'b0;
          dup_pend = dup_en && valid_en;
        end else v_wait--;
      end
      if (core_done) begin
        t_pend = 1'b1; t_wait = $urandom_range(0, 5);
      end else if (t_pend) begin
        if (t_wait == 0) begin
          core_tag_ok = 1'b1; core_tag = fold ^ {core_nonce, 32'h0}; t_pend = 1'b0;
        end else t_wait--;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (core_init) init_cnt++;
      if (core_next) begin
        check("core_data_in", core_data_in, exp_block(next_cnt));
        check("core_latched", 512'({core_encdec, core_key, core_nonce}), 512'({cur_encdec, cur_key, cur_nonce}));
        next_cnt++;
      end
      if (core_done) done_cnt++;
      if (tag_valid) begin
        tag_pulses++;
        check("tag_out", 512'(tag_out), 512'(exp_tag));
        check("auth_fail_at_tag", 512'(auth_fail), 512'(exp_auth));
      end
    end
  end

  task automatic fill_random(input int len);
    msg.delete();
    for (int j = 0; j < len; j++) msg.push_back(rand128());
  endtask

  task automatic setup(input bit enc, input bit bad);
    cur_key = {rand128(), rand128()};
    cur_nonce = {$urandom, $urandom, $urandom};
    cur_encdec = enc;
    exp_tag = model_tag();
    exp_auth = !enc && bad;
    expected_tag = bad ? (exp_tag ^ 128'h1) : exp_tag;
    init_cnt = 0; next_cnt = 0; done_cnt = 0; tag_pulses = 0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1; encdec_in = cur_encdec; key_in = cur_key; nonce_in = cur_nonce;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit rnd);
    for (int j = 0; j < msg.size(); j++) begin
      int w = 0;
      if (rnd) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      s_valid = 1'b1; s_data = msg[j]; s_last = (j == msg.size() - 1);
      while (!s_ready && w < BUDGET) begin @(negedge clk); w++; end
      check("s_ready_seen", 512'(s_ready), 512'(1));
      if (!s_ready) break;
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic consume(input int stall_at, input bit rnd);
    logic [127:0] held;
    bit stable;
    for (int j = 0; j < msg.size(); j++) begin
      int w = 0;
      if (j == stall_at) begin
        m_ready = 1'b0;
        while (!m_valid && w < BUDGET) begin @(negedge clk); w++; end
        held = m_data; stable = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (m_data !== held || !m_valid || s_ready) stable = 1'b0;
        end
        check("stall_hold", 512'(stable), 512'(1));
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      while (!(m_valid && m_ready) && w < BUDGET) begin
        @(negedge clk); w++;
        m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      check("m_handshake", 512'(m_valid && m_ready), 512'(1));
      check("m_data", 512'(m_data), 512'(exp_word(j)));
      check("m_last", 512'(m_last), 512'(j == msg.size() - 1));
      if (!(m_valid && m_ready)) break;
      @(negedge clk);
    end
    m_ready = 1'b0;
  endtask

  task automatic run_msg(input bit enc, input bit bad, input int stall_at, input bit rnd);
    int w = 0;
    setup(enc, bad);
    do_start();
    check("start_clears", 512'({err, auth_fail, tag_out}), 512'(0));
    fork
      feed(rnd);
      consume(stall_at, rnd);
    join
    while (tag_pulses == 0 && w < BUDGET) begin @(negedge clk); w++; end
    repeat (3) @(negedge clk);
    check("tag_pulses", 512'(tag_pulses), 512'(1));
    check("init_pulses", 512'(init_cnt), 512'(1));
    check("next_pulses", 512'(next_cnt), 512'((msg.size() + 3) / 4));
    check("done_pulses", 512'(done_cnt), 512'(1));
    check("idle_flags", 512'({busy, err}), 512'(0));
    check("auth_fail", 512'(auth_fail), 512'(exp_auth));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int k;
    logic [127:0] cw;
    rst = 1'b1; start = 1'b0; encdec_in = 1'b0; key_in = '0; nonce_in = '0;
    expected_tag = '0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    core_data_out = '0; core_tag = '0; core_ready = 1'b0; core_valid = 1'b0; core_tag_ok = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 512'({s_ready, m_valid, m_data, m_last, tag_out, tag_valid, auth_fail, err, busy,
                              core_init, core_next, core_done, core_encdec}), 512'(0));
    check("reset_key", 512'({core_key, core_nonce}), 512'(0));
    check("reset_block", core_data_in, 512'(0));
    rst = 1'b0;
    @(negedge clk);

    // Four identical words: one block of {4{word}}.
    cw = 128'hcafebabedeadbeefcafebabedeadbeef;
    msg.delete();
    repeat (4) msg.push_back(cw);
    run_msg(1'b1, 1'b0, -1, 1'b0);

    fill_random(6);
    run_msg(1'b1, 1'b0, -1, 1'b1);

    fill_random(5);
    run_msg(1'b0, 1'b0, -1, 1'b1);

    fill_random(3);
    run_msg(1'b0, 1'b1, -1, 1'b0);
    repeat (5) @(negedge clk);
    check("auth_fail_sticky", 512'(auth_fail), 512'(1));

    fill_random(8);
    run_msg(1'b1, 1'b0, 1, 1'b0);

    dup_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      fill_random($urandom_range(1, 9));
      run_msg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b1);
    end
    dup_en = 1'b0;

    // core_valid withheld: the wait for it must time out.
    fill_random(3);
    setup(1'b1, 1'b0);
    valid_en = 1'b0;
    do_start();
    k = 0;
    fork
      feed(1'b0);
      begin
        w = 0;
        while (!core_next && w < BUDGET) begin @(negedge clk); w++; end
        // WAIT_VALID is entered on the edge after core_next; err follows TMO cycles later.
        do begin @(negedge clk); k++; end while (!err && k < 4 * TMO);
      end
    join
    check("timeout_cycles", 512'(k), 512'(TMO + 1));
    check("abort_quiet", 512'({busy, m_valid, s_ready, tag_valid, core_init, core_next, core_done}), 512'(7'b1000000));
    @(negedge clk);
    check("abort_idle", 512'({busy, err}), 512'(2'b01));
    repeat (5) @(negedge clk);
    check("abort_no_tag", 512'(tag_pulses), 512'(0));
    valid_en = 1'b1;
    fill_random(2);
    run_msg(1'b1, 1'b0, -1, 1'b0);

    // Reset asserted while output words are pending.
    fill_random(4);
    setup(1'b1, 1'b0);
    m_ready = 1'b0;
    do_start();
    fork
      feed(1'b0);
      begin
        w = 0;
        while (!m_valid && w < BUDGET) begin @(negedge clk); w++; end
      end
    join
    check("drain_reached", 512'(m_valid), 512'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_ctrl", 512'({s_ready, m_valid, m_data, m_last, tag_out, tag_valid, auth_fail, err, busy,
                                  core_init, core_next, core_done, core_encdec}), 512'(0));
    check("async_rst_key", 512'({core_key, core_nonce}), 512'(0));
    check("async_rst_block", core_data_in, 512'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 512'(busy), 512'(0));
    fill_random(7);
    run_msg(1'b0, 1'b0, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
